// File: rtl/cascade_sequencer.sv
// Viola-Jones cascade sequencer for one detection window: walks every feature of
// each stage over a valid/ready handshake, sums the votes and tests each stage threshold.
module cascade_sequencer #(
  parameter int NUM_STAGES = 22,
  parameter int IDX_W      = 12,
  parameter int VOTE_W     = 16,
  parameter int SUM_W      = 20
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  output logic [31:0]              stage_num,
  input  logic [31:0]              feat_amount,
  input  logic signed [VOTE_W-1:0] stage_thresh,
  output logic                     feat_valid,
  input  logic                     feat_ready,
  output logic [IDX_W-1:0]         feat_idx,
  input  logic                     res_valid,
  input  logic signed [VOTE_W-1:0] vote,
  output logic                     busy,
  output logic                     done,
  output logic                     face
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic signed [SUM_W-1:0] acc_reg;
  logic [7:0]              cnt_reg;
  logic [7:0]              lidx_reg;

  logic signed [SUM_W-1:0] vote_ext;
  logic signed [SUM_W-1:0] thresh_ext;
  logic                    stage_pass;
  logic                    last_feat;
  logic                    last_stage;
  logic                    unused_amount_bits;

  // Only the low byte of the feature count is meaningful.
  assign unused_amount_bits = ^feat_amount[31:8];

  assign vote_ext   = {{(SUM_W-VOTE_W){vote[VOTE_W-1]}}, vote};
  assign thresh_ext = {{(SUM_W-VOTE_W){stage_thresh[VOTE_W-1]}}, stage_thresh};
  assign stage_pass = (acc_reg >= thresh_ext);
  assign last_feat  = (lidx_reg == (cnt_reg - 8'd1));
  assign last_stage = (stage_num == 32'(NUM_STAGES - 1));

  assign feat_valid = (state_reg == S_ISSUE);
  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  state_next = (feat_amount[7:0] == 8'd0) ? S_CHECK : S_ISSUE;
      S_ISSUE: if (feat_ready) state_next = S_WAIT;
      S_WAIT:  if (res_valid) state_next = last_feat ? S_CHECK : S_ISSUE;
      S_CHECK: state_next = (!stage_pass || last_stage) ? S_DONE : S_LOAD;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stage_num <= '0;
      feat_idx  <= '0;
      face      <= 1'b0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      lidx_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            stage_num <= '0;
            feat_idx  <= '0;
            face      <= 1'b0;
          end
        end
        S_LOAD: begin
          cnt_reg  <= feat_amount[7:0];
          lidx_reg <= '0;
          acc_reg  <= '0;
        end
        S_WAIT: begin
          // The accumulator wraps on overflow by design.
          if (res_valid) begin
            acc_reg  <= acc_reg + vote_ext;
            feat_idx <= feat_idx + IDX_W'(1);
            if (!last_feat) lidx_reg <= lidx_reg + 8'd1;
          end
        end
        S_CHECK: begin
          if (!stage_pass) begin
            face <= 1'b0;
          end else if (last_stage) begin
            face <= 1'b1;
          end else begin
            stage_num <= stage_num + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cascade_sequencer.sv
// Self-checking bench for cascade_sequencer: a behavioural evaluator drives the
// handshake while a cascade reference model predicts handshakes, face and final stage.
module tb_cascade_sequencer;

  localparam int NS     = 22;
  localparam int IDX_W  = 12;
  localparam int VOTE_W = 16;
  localparam int SUM_W  = 20;
  localparam int LOG_SZ = 16384;

  logic                     Clk = 1'b0;
  logic                     Reset;
  logic                     start;
  logic [31:0]              stage_num;
  logic [31:0]              feat_amount;
  logic signed [VOTE_W-1:0] stage_thresh;
  logic                     feat_valid;
  logic                     feat_ready;
  logic [IDX_W-1:0]         feat_idx;
  logic                     res_valid;
  logic signed [VOTE_W-1:0] vote;
  logic                     busy;
  logic                     done;
  logic                     face;

  cascade_sequencer #(
    .NUM_STAGES(NS), .IDX_W(IDX_W), .VOTE_W(VOTE_W), .SUM_W(SUM_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .stage_num(stage_num),
    .feat_amount(feat_amount), .stage_thresh(stage_thresh),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_idx(feat_idx),
    .res_valid(res_valid), .vote(vote), .busy(busy), .done(done), .face(face)
  );

  always #5 Clk = ~Clk;

  // Cascade tables
  int amt_tbl[NS];
  int thr_tbl[NS];
  int vote_tbl[4096];

  always_comb begin
    feat_amount  = '0;
    stage_thresh = '0;
    if (stage_num < NS) begin
      feat_amount  = 32'(amt_tbl[stage_num]);
      stage_thresh = VOTE_W'(thr_tbl[stage_num]);
    end
  end

  // Evaluator controls and state
  int   bp_hold;
  int   max_lat;
  bit   rand_ready;
  bit   spur_en;
  bit   pend;
  int   lat_left;
  logic signed [VOTE_W-1:0] pend_vote;
  int   hs_n;
  int   hs_log[LOG_SZ];
  int   stab_err;
  bit   have_prev;
  logic [IDX_W-1:0] prev_idx;
  int   bp_cnt;

  initial begin
    feat_ready = 1'b0;
    res_valid  = 1'b0;
    vote       = '0;
    pend       = 1'b0;
    lat_left   = 0;
    pend_vote  = '0;
    hs_n       = 0;
    stab_err   = 0;
    have_prev  = 1'b0;
    prev_idx   = '0;
    bp_cnt     = 0;
  end

  // Decisions made on the falling edge are what the DUT samples on the next rising edge.
  always @(negedge Clk) begin
    bit fired;
    fired     = 1'b0;
    res_valid = 1'b0;
    if (Reset) begin
      pend       = 1'b0;
      feat_ready = 1'b0;
      bp_cnt     = 0;
      have_prev  = 1'b0;
    end else begin
      if (pend) begin
        if (lat_left == 0) begin
          res_valid = 1'b1;
          vote      = pend_vote;
          pend      = 1'b0;
          fired     = 1'b1;
        end else begin
          lat_left--;
        end
      end
      if (feat_valid) begin
        if (have_prev && feat_idx !== prev_idx) stab_err++;
        if (bp_cnt < bp_hold) begin
          feat_ready = 1'b0;
          bp_cnt++;
        end else if (rand_ready) begin
          feat_ready = ($urandom_range(0, 2) != 0);
        end else begin
          feat_ready = 1'b1;
        end
        if (feat_ready) begin
          hs_log[hs_n % LOG_SZ] = int'(feat_idx);
          hs_n++;
          pend      = 1'b1;
          lat_left  = (max_lat > 1) ? int'($urandom_range(1, max_lat)) - 1 : 0;
          pend_vote = VOTE_W'(vote_tbl[feat_idx]);
          bp_cnt    = 0;
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev_idx  = feat_idx;
        end
      end else begin
        if (have_prev) stab_err++;
        have_prev  = 1'b0;
        feat_ready = spur_en ? ($urandom_range(0, 1) == 1) : 1'b0;
      end
      if (!fired && spur_en && (feat_valid || !busy) && $urandom_range(0, 3) == 0) begin
        res_valid = 1'b1;
        vote      = VOTE_W'(int'($urandom_range(0, 200)) - 100);
      end
    end
  end

  // Scoreboard
  int vectors;
  int miscompares;
  int exp_hs[4096];
  int exp_n;
  int exp_face;
  int exp_stage;

  function automatic int wrap_sum(int x);
    return (x <<< (32 - SUM_W)) >>> (32 - SUM_W);
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Reference cascade: stop at the first stage whose vote sum misses its threshold.
  task automatic model();
    int gidx;
    int sum;
    exp_n     = 0;
    gidx      = 0;
    exp_face  = 0;
    exp_stage = 0;
    for (int s = 0; s < NS; s++) begin
      exp_stage = s;
      sum = 0;
      for (int f = 0; f < amt_tbl[s]; f++) begin
        exp_hs[exp_n] = gidx;
        exp_n++;
        sum = wrap_sum(sum + vote_tbl[gidx]);
        gidx++;
      end
      if (sum < thr_tbl[s]) begin
        exp_face = 0;
        break;
      end
      if (s == NS - 1) exp_face = 1;
    end
  endtask

  task automatic run_window(input string tag, input bit ideal);
    int base, se, c, got_face, got_stage, lat, got_n, ncmp;
    bit finished;
    model();
    base      = hs_n;
    se        = stab_err;
    c         = 0;
    lat       = -1;
    got_face  = -1;
    got_stage = -1;
    finished  = 1'b0;
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 0; k < 20000 && !finished; k++) begin
      if (done) begin
        got_face  = int'(face);
        got_stage = int'(stage_num);
        lat       = c;
        start     = 1'b0;
        @(negedge Clk);
        chk({tag, "/done_one_cycle"}, int'(done), 0);
        chk({tag, "/idle_after_done"}, int'(busy), 0);
        finished = 1'b1;
      end else begin
        start = spur_en && busy && ($urandom_range(0, 4) == 0);
        @(negedge Clk);
        c++;
      end
    end
    start = 1'b0;
    chk({tag, "/done_seen"}, int'(finished), 1);
    chk({tag, "/face"}, got_face, exp_face);
    chk({tag, "/stage_num"}, got_stage, exp_stage);
    got_n = hs_n - base;
    chk({tag, "/handshakes"}, got_n, exp_n);
    ncmp = (got_n < exp_n) ? got_n : exp_n;
    for (int i = 0; i < ncmp; i++)
      chk({tag, "/feat_idx"}, hs_log[(base + i) % LOG_SZ], exp_hs[i]);
    chk({tag, "/issue_stable"}, stab_err - se, 0);
    if (ideal) chk({tag, "/latency"}, lat, 2 * (exp_stage + 1) + 2 * exp_n);
    repeat (3) @(negedge Clk);
    chk({tag, "/face_held"}, int'(face), exp_face);
    $display("window %s: handshakes=%0d face=%0d stage=%0d cycles=%0d",
             tag, got_n, got_face, got_stage, lat);
  endtask

  task automatic set_ideal();
    bp_hold    = 0;
    max_lat    = 1;
    rand_ready = 1'b0;
    spur_en    = 1'b0;
  endtask

  task automatic fill_votes(input int v);
    for (int i = 0; i < 4096; i++) vote_tbl[i] = v;
  endtask

  initial begin
    int n0;
    bit hit;
    vectors     = 0;
    miscompares = 0;
    Reset       = 1'b1;
    start       = 1'b0;
    set_ideal();
    for (int s = 0; s < NS; s++) begin
      amt_tbl[s] = 0;
      thr_tbl[s] = 0;
    end
    fill_votes(1);

    repeat (3) @(negedge Clk);
    chk("reset/busy", int'(busy), 0);
    chk("reset/done", int'(done), 0);
    chk("reset/feat_valid", int'(feat_valid), 0);
    chk("reset/face", int'(face), 0);
    chk("reset/stage_num", int'(stage_num), 0);
    chk("reset/feat_idx", int'(feat_idx), 0);
    Reset = 1'b0;

    // Full cascade: 21 x 97 + 98 = 2135 features, all votes +1, thresholds 0
    for (int s = 0; s < NS; s++) amt_tbl[s] = (s == NS - 1) ? 98 : 97;
    run_window("full_pass", 1'b1);

    // Stage-0 reject
    amt_tbl[0] = 3;
    fill_votes(-1);
    run_window("stage0_reject", 1'b1);

    // Threshold equality passes, one above fails
    vote_tbl[0] = 5; vote_tbl[1] = 5; vote_tbl[2] = -3;
    amt_tbl[1] = 2;
    thr_tbl[0] = 7;
    run_window("thresh_equal", 1'b1);
    thr_tbl[0] = 8;
    run_window("thresh_above", 1'b1);
    thr_tbl[0] = 0;

    // Backpressure: ready held low 5 cycles per issue
    fill_votes(1);
    for (int s = 0; s < NS; s++) amt_tbl[s] = 4;
    bp_hold = 5;
    run_window("backpressure", 1'b0);
    bp_hold = 0;

    // Spurious res_valid/start/ready and a zero-feature stage
    spur_en = 1'b1;
    for (int s = 0; s < NS; s++) amt_tbl[s] = 3;
    amt_tbl[1] = 0;
    run_window("spurious_empty_pass", 1'b0);
    thr_tbl[1] = 1;
    run_window("spurious_empty_fail", 1'b0);
    thr_tbl[1] = 0;
    set_ideal();

    // Asynchronous reset while a response is in flight
    for (int s = 0; s < NS; s++) amt_tbl[s] = 5;
    n0  = hs_n;
    hit = 1'b0;
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge Clk);
      #1;
      if (hs_n - n0 >= 30 && res_valid) hit = 1'b1;
    end
    chk("rst_wait/reached_wait", int'(hit), 1);
    chk("rst_wait/pre_stage_nonzero", int'(stage_num != 0), 1);
    #1 Reset = 1'b1;
    #1;
    chk("rst_wait/busy", int'(busy), 0);
    chk("rst_wait/feat_valid", int'(feat_valid), 0);
    chk("rst_wait/done", int'(done), 0);
    chk("rst_wait/face", int'(face), 0);
    chk("rst_wait/stage_num", int'(stage_num), 0);
    chk("rst_wait/feat_idx", int'(feat_idx), 0);
    repeat (2) @(negedge Clk);
    #1 Reset = 1'b0;
    run_window("restart_after_reset", 1'b1);

    // Randomised cascades
    for (int w = 0; w < 8; w++) begin
      for (int s = 0; s < NS; s++) begin
        amt_tbl[s] = int'($urandom_range(0, 12));
        thr_tbl[s] = int'($urandom_range(0, 25)) - 10;
      end
      for (int i = 0; i < 4096; i++) vote_tbl[i] = int'($urandom_range(0, 10)) - 4;
      rand_ready = 1'b1;
      max_lat    = 3;
      spur_en    = 1'b1;
      bp_hold    = (w % 2 == 0) ? 0 : 2;
      run_window($sformatf("random_%0d", w), 1'b0);
    end
    set_ideal();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
